// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the renderer/MPU RAM arbiter: owner tags that travel
// down the read-return pipeline alongside each RAM command.
package mem_arbiter_pkg;

    localparam int TAG_WIDTH = 2;

    typedef enum logic [TAG_WIDTH-1:0] {
        OWNER_NONE   = 2'd0,
        OWNER_RENDER = 2'd1,
        OWNER_MPU    = 2'd2
    } owner_t;

    // Writes produce no return data, so only reads carry an owner down the pipe.
    function automatic owner_t read_owner(input logic render_xfer,
                                          input logic mpu_xfer,
                                          input logic mpu_wr);
        owner_t owner;
        owner = OWNER_NONE;
        if (render_xfer)
            owner = OWNER_RENDER;
        else if (mpu_xfer && !mpu_wr)
            owner = OWNER_MPU;
        return owner;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the MPU request has been refused;
// flags starvation once the count reaches MAX_WAIT.
module arb_starve_counter #(
    parameter int MAX_WAIT   = 4,
    parameter int WAIT_WIDTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic mpu_req,
    input  logic mpu_gnt,
    output logic starved
);

    localparam logic [WAIT_WIDTH-1:0] MAX_CNT = WAIT_WIDTH'(MAX_WAIT);

    logic [WAIT_WIDTH-1:0] wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (!mpu_req || mpu_gnt)
            wait_cnt <= '0;
        else if (wait_cnt != MAX_CNT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign starved = mpu_req && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between the renderer (priority,
// read-only) and the MPU bus, with bounded MPU starvation and tagged read returns.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4,
    parameter int WAIT_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  render_req,
    input  logic [ADDR_WIDTH-1:0] render_addr,
    output logic                  render_gnt,
    output logic                  render_rvalid,
    output logic [DATA_WIDTH-1:0] render_rdata,

    input  logic                  mpu_req,
    input  logic                  mpu_wr,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [DATA_WIDTH-1:0] mpu_wdata,
    output logic                  mpu_gnt,
    output logic                  mpu_rvalid,
    output logic [DATA_WIDTH-1:0] mpu_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic   starved;
    owner_t tag_s1;
    owner_t tag_s2;

    arb_starve_counter #(
        .MAX_WAIT   (MAX_WAIT),
        .WAIT_WIDTH (WAIT_WIDTH)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .mpu_req (mpu_req),
        .mpu_gnt (mpu_gnt),
        .starved (starved)
    );

    // Grants are masked during reset so every output reads 0 while it is held.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        mpu_gnt    = 1'b0;
        render_gnt = 1'b0;
        if (!reset) begin
            mpu_gnt    = mpu_req && (starved || !render_req);
            render_gnt = render_req && !mpu_gnt;
        end
    end

    // Command register plus stage-1 tag; idle cycles present a cleared command.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            tag_s1    <= OWNER_NONE;
            tag_s2    <= OWNER_NONE;
        end else begin
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            tag_s1    <= read_owner(render_gnt, mpu_gnt, mpu_wr);
            tag_s2    <= tag_s1;
            if (render_gnt) begin
                mem_addr <= render_addr;
                mem_rd   <= 1'b1;
            end else if (mpu_gnt) begin
                mem_addr  <= mpu_addr;
                mem_rd    <= !mpu_wr;
                mem_wr    <= mpu_wr;
                mem_wdata <= mpu_wr ? mpu_wdata : '0;
            end
        end
    end

    // RAM data arrives in the cycle the stage-2 tag names its owner.
    always_comb begin
        render_rvalid = (tag_s2 == OWNER_RENDER);
        mpu_rvalid    = (tag_s2 == OWNER_MPU);
        render_rdata  = render_rvalid ? mem_rdata : '0;
        mpu_rdata     = mpu_rvalid    ? mem_rdata : '0;
    end

    a_one_grant : assert property (@(posedge clk) !(render_gnt && mpu_gnt));
    a_one_rvalid : assert property (@(posedge clk) !(render_rvalid && mpu_rvalid));
    a_one_cmd : assert property (@(posedge clk) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a reference model.
module tb_mem_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 8;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          render_req = 1'b0;
    logic [AW-1:0] render_addr = '0;
    logic          render_gnt, render_rvalid;
    logic [DW-1:0] render_rdata;
    logic          mpu_req = 1'b0;
    logic          mpu_wr = 1'b0;
    logic [AW-1:0] mpu_addr = '0;
    logic [DW-1:0] mpu_wdata = '0;
    logic          mpu_gnt, mpu_rvalid;
    logic [DW-1:0] mpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_WAIT   (MAXW),
        .WAIT_WIDTH (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .render_req    (render_req),
        .render_addr   (render_addr),
        .render_gnt    (render_gnt),
        .render_rvalid (render_rvalid),
        .render_rdata  (render_rdata),
        .mpu_req       (mpu_req),
        .mpu_wr        (mpu_wr),
        .mpu_addr      (mpu_addr),
        .mpu_wdata     (mpu_wdata),
        .mpu_gnt       (mpu_gnt),
        .mpu_rvalid    (mpu_rvalid),
        .mpu_rdata     (mpu_rdata),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 4096x8 synchronous RAM, preloaded with ~addr.
    logic [DW-1:0] ram [4096];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = ~i[7:0];
        forever begin
            @(posedge clk);
            if (mem_wr === 1'b1) ram[mem_addr] = mem_wdata;
            if (mem_rd === 1'b1) mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model: who is owed data when, and what the RAM must contain.
    typedef struct {
        int            owner;  // 1 = renderer, 2 = MPU
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          all_zero;
    } cmd_t;

    logic [DW-1:0] ref_mem [4096];
    ret_t          pend[$];
    cmd_t          exp_cmd = '{rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0, all_zero: 1'b1};
    int            refused = 0;
    logic [DW-1:0] rcap_data[$];
    int            rcap_cyc[$];

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = ~i[7:0];
        forever begin
            @(negedge clk);
            begin
                logic          exp_mg, exp_rg;
                int            r_owner;
                logic [DW-1:0] r_data;
                ret_t          keep[$];

                // Renderer wins unless the MPU has already been turned away MAXW times running.
                exp_mg = 1'b0;
                exp_rg = 1'b0;
                if (!reset) begin
                    if (mpu_req && (!render_req || refused >= MAXW)) exp_mg = 1'b1;
                    else if (render_req) exp_rg = 1'b1;
                end

                r_owner = 0;
                r_data  = '0;
                foreach (pend[i]) if (pend[i].due == cyc) begin
                    r_owner = pend[i].owner;
                    r_data  = pend[i].data;
                end

                if (cyc >= 1) begin
                    check("render_gnt", 32'(render_gnt), 32'(exp_rg));
                    check("mpu_gnt", 32'(mpu_gnt), 32'(exp_mg));
                    check("mem_rd", 32'(mem_rd), 32'(exp_cmd.rd));
                    check("mem_wr", 32'(mem_wr), 32'(exp_cmd.wr));
                    if (exp_cmd.rd || exp_cmd.wr || exp_cmd.all_zero)
                        check("mem_addr", 32'(mem_addr), 32'(exp_cmd.addr));
                    if (exp_cmd.wr || exp_cmd.all_zero)
                        check("mem_wdata", 32'(mem_wdata), 32'(exp_cmd.wdata));
                    check("render_rvalid", 32'(render_rvalid), 32'(r_owner == 1));
                    check("render_rdata", 32'(render_rdata), (r_owner == 1) ? 32'(r_data) : 32'd0);
                    check("mpu_rvalid", 32'(mpu_rvalid), 32'(r_owner == 2));
                    check("mpu_rdata", 32'(mpu_rdata), (r_owner == 2) ? 32'(r_data) : 32'd0);
                    if (render_rvalid === 1'b1) begin
                        rcap_data.push_back(render_rdata);
                        rcap_cyc.push_back(cyc);
                    end
                end

                foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
                pend = keep;

                exp_cmd = '{rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0, all_zero: 1'b0};
                if (reset) begin
                    pend.delete();
                    exp_cmd.all_zero = 1'b1;
                    refused = 0;
                end else begin
                    if (exp_rg) begin
                        exp_cmd.rd   = 1'b1;
                        exp_cmd.addr = render_addr;
                        pend.push_back('{owner: 1, data: ref_mem[render_addr], due: cyc + 2});
                    end else if (exp_mg) begin
                        exp_cmd.addr = mpu_addr;
                        if (mpu_wr) begin
                            exp_cmd.wr          = 1'b1;
                            exp_cmd.wdata       = mpu_wdata;
                            ref_mem[mpu_addr]   = mpu_wdata;
                        end else begin
                            exp_cmd.rd = 1'b1;
                            pend.push_back('{owner: 2, data: ref_mem[mpu_addr], due: cyc + 2});
                        end
                    end
                    if (!mpu_req || exp_mg) refused = 0;
                    else if (refused < MAXW) refused++;
                end
            end
        end
    end

    // Returns just after the edge that completed the transfer.
    task automatic mpu_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int waited, output logic rg_at_gnt);
        @(posedge clk); #1;
        mpu_req = 1'b1; mpu_wr = wr; mpu_addr = a; mpu_wdata = d;
        waited = 0;
        rg_at_gnt = 1'b1;
        while (1) begin
            @(negedge clk);
            if (mpu_gnt === 1'b1) begin
                rg_at_gnt = render_gnt;
                break;
            end
            waited++;
            if (waited > 40) begin
                check("mpu_gnt_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        mpu_req = 1'b0; mpu_wr = 1'b0;
    endtask

    task automatic render_op(input logic [AW-1:0] a);
        int waited;
        @(posedge clk); #1;
        render_req = 1'b1; render_addr = a;
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (render_gnt === 1'b1) break;
            waited++;
            if (waited > 40) begin
                check("render_gnt_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        render_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        logic rg;
        int   sent;
        int   guard;
        logic rt, mt;

        // Reset held three edges with both requests up.
        render_req = 1'b1;
        mpu_req    = 1'b1;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check("rst_render_gnt", 32'(render_gnt), 32'd0);
            check("rst_mpu_gnt", 32'(mpu_gnt), 32'd0);
            check("rst_mem_rd", 32'(mem_rd), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
            @(posedge clk);
        end
        #1;
        reset = 1'b0; render_req = 1'b0; mpu_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rvalid", 32'(render_rvalid | mpu_rvalid), 32'd0);
        end

        // MPU write then read back.
        mpu_op(1'b1, 12'h123, 8'hA5, w, rg);
        @(negedge clk);
        check("t2_wr_pulse", 32'(mem_wr), 32'd1);
        check("t2_wr_addr", 32'(mem_addr), 32'h123);
        check("t2_wr_data", 32'(mem_wdata), 32'hA5);
        @(negedge clk);
        check("t2_wr_one_cycle", 32'(mem_wr), 32'd0);
        check("t2_wr_no_rvalid", 32'(mpu_rvalid), 32'd0);
        mpu_op(1'b0, 12'h123, 8'h00, w, rg);
        @(negedge clk);
        check("t2_rvalid_early", 32'(mpu_rvalid), 32'd0);
        @(negedge clk);
        check("t2_rvalid", 32'(mpu_rvalid), 32'd1);
        check("t2_rdata", 32'(mpu_rdata), 32'hA5);

        // Renderer burst 0x000..0x007.
        @(posedge clk); #1;
        rcap_data.delete();
        rcap_cyc.delete();
        render_req = 1'b1; render_addr = '0;
        sent = 0; guard = 0;
        while (sent < 8 && guard < 50) begin
            @(negedge clk);
            if (render_gnt === 1'b1) sent++;
            guard++;
            @(posedge clk); #1;
            if (sent < 8) render_addr = AW'(sent);
            else render_req = 1'b0;
        end
        check("t3_grants", 32'(sent), 32'd8);
        repeat (4) @(negedge clk);
        check("t3_returns", 32'(rcap_data.size()), 32'd8);
        for (int i = 0; i < rcap_data.size() && i < 8; i++) begin
            check("t3_data", 32'(rcap_data[i]), 32'hFF - 32'(i));
            check("t3_back_to_back", 32'(rcap_cyc[i] - rcap_cyc[0]), 32'(i));
        end

        // Starvation bound under continuous renderer traffic.
        @(posedge clk); #1;
        render_req = 1'b1; render_addr = 12'h020;
        mpu_op(1'b0, 12'h010, 8'h00, w, rg);
        check("t4_refused_cycles", 32'(w), 32'(MAXW));
        check("t4_render_held_off", 32'(rg), 32'd0);
        @(negedge clk);
        check("t4_render_resumes", 32'(render_gnt), 32'd1);
        @(negedge clk);
        check("t4_mpu_rvalid", 32'(mpu_rvalid), 32'd1);
        check("t4_mpu_rdata", 32'(mpu_rdata), 32'hEF);
        @(posedge clk); #1;
        render_req = 1'b0;
        repeat (3) @(posedge clk);

        // Interleave: simultaneous requests, renderer first.
        #1;
        render_req = 1'b1; render_addr = 12'h001;
        mpu_req = 1'b1; mpu_wr = 1'b0; mpu_addr = 12'h002;
        @(negedge clk);
        check("t5_render_first", 32'(render_gnt), 32'd1);
        check("t5_mpu_waits", 32'(mpu_gnt), 32'd0);
        @(posedge clk); #1;
        render_req = 1'b0;
        @(negedge clk);
        check("t5_mpu_next", 32'(mpu_gnt), 32'd1);
        @(posedge clk); #1;
        mpu_req = 1'b0;
        @(negedge clk);
        check("t5_render_rvalid", 32'({render_rvalid, mpu_rvalid}), 32'b10);
        check("t5_render_rdata", 32'(render_rdata), 32'hFE);
        @(negedge clk);
        check("t5_mpu_rvalid", 32'({render_rvalid, mpu_rvalid}), 32'b01);
        check("t5_mpu_rdata", 32'(mpu_rdata), 32'hFD);

        // Reset the cycle after a renderer grant.
        @(posedge clk); #1;
        render_req = 1'b1; render_addr = 12'h003;
        @(negedge clk);
        check("t6_gnt", 32'(render_gnt), 32'd1);
        @(posedge clk); #1;
        render_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_discarded", 32'(render_rvalid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_still_quiet", 32'(render_rvalid), 32'd0);
        render_op(12'h005);
        @(negedge clk);
        @(negedge clk);
        check("t6_new_rvalid", 32'(render_rvalid), 32'd1);
        check("t6_new_rdata", 32'(render_rdata), 32'hFA);

        // Randomized traffic on a small address window to exercise read-after-write.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            rt = render_req && render_gnt;
            mt = mpu_req && mpu_gnt;
            @(posedge clk); #1;
            reset = ($urandom_range(0, 99) == 0);
            if (!render_req || rt) begin
                render_req  = ($urandom_range(0, 3) != 0);
                render_addr = AW'($urandom_range(0, 15));
            end else if ($urandom_range(0, 19) == 0) begin
                render_req = 1'b0;
            end
            if (!mpu_req || mt) begin
                mpu_req   = ($urandom_range(0, 2) == 0);
                mpu_wr    = $urandom_range(0, 1) == 1;
                mpu_addr  = AW'($urandom_range(0, 15));
                mpu_wdata = DW'($urandom_range(0, 255));
            end else if ($urandom_range(0, 9) == 0) begin
                mpu_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; render_req = 1'b0; mpu_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
